selfadd_accum_lanes: RTL and testbench
======================================

Name: selfadd_accum_lanes

Overview:
- Parametrised multi-lane self-accumulating register bank. Each accepted input vector is added lane-by-lane into a per-lane accumulator through a pipelined adder.
- Generalises the 2x16b self-add unit. Adds configurable lane count, width and adder latency; a valid/ready input handshake with hazard-safe throttling; wrap or saturating modes; sticky per-lane overflow flags; and a sample counter.
- Sits as the leaf unit of accumulation heaps (e.g. 64x16b banks), fed by the feature datapath.

Parameters:
- LANES, 2, number of independent accumulator lanes (>=1).
- WIDTH, 16, bits per lane.
- ADD_LAT, 2, adder pipeline depth in cycles (>=1).
- MODE, 0, 0 = unsigned wrap, 1 = unsigned saturate, 2 = two's-complement signed saturate.
- CNT_W, 8, width of the accepted-sample counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low.
- usr_clr  in  1  synchronous user clear, active-high.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept; transfer happens on an edge where in_valid && in_ready.
- in_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- out_data  out  LANES*WIDTH  current accumulator contents, registered.
- out_valid  out  1  one-cycle pulse: out_data has just been updated.
- ovf  out  LANES  sticky per-lane overflow flags.
- acc_cnt  out  CNT_W  number of accumulations since clear; saturates at all-ones.

Behaviour:
- Reset (rst=0 at an edge): acc=0, out_valid=0, ovf=0, acc_cnt=0, pipeline flushed. in_ready=0 while rst=0 and 1 in the first cycle after rst returns to 1.
- in_ready = rst && !usr_clr && !busy.
- Accept at edge E0:
  - Stage 0 captures in_data and the accumulator snapshot; busy is set.
  - The sum moves through ADD_LAT register stages.
  - The accumulator, ovf and acc_cnt are written at edge E0+ADD_LAT.
  - out_valid=1 for exactly the cycle after E0+ADD_LAT.
- Throttling: busy clears at edge E0+ADD_LAT, so in_ready is high in the same cycle out_valid is high. The next accept can occur at E0+ADD_LAT+1 at the earliest. Peak throughput is one vector per ADD_LAT+1 cycles. This removes the read-after-write hazard without bypass.
- Arithmetic per lane, on a WIDTH+1-bit sum:
  - MODE 0: keep the low WIDTH bits; overflow = carry out.
  - MODE 1: on carry, result = all-ones; overflow = carry.
  - MODE 2: overflow when both operands share a sign and the result sign differs. Result = 0x7F..F for positive overflow, 0x80..0 for negative overflow.
- ovf[i] is set on any overflow event in lane i and stays set until rst or usr_clr. Lanes are fully independent.
- acc_cnt increments at each accumulator write and holds at 2^CNT_W-1.
- usr_clr=1 at an edge:
  - acc, ovf and acc_cnt cleared; pipeline and busy flushed.
  - An in-flight result is discarded and produces no out_valid.
  - in_valid in the same cycle is not accepted, because in_ready=0.
  - in_ready=1 the next cycle if usr_clr has returned to 0.
- Holding usr_clr high keeps the block cleared.
- in_data is ignored when no transfer occurs. in_valid may drop without a transfer.

Decomposition:
- Shared package selfadd_pkg holds the MODE_WRAP=0, MODE_USAT=1 and MODE_SSAT=2 constants and a function computing the saturated result plus overflow flag.
- One sub-module, selfadd_lane: a single-lane ADD_LAT pipeline with mode logic and a sticky ovf bit, instantiated LANES times.
- Handshake, busy counter, out_valid and acc_cnt live in the top level.

Test Plan:
- Accumulation and timing (LANES=2, WIDTH=16, ADD_LAT=2, MODE=0): in_valid held high with in_data={0x0001,0x0002} (lane1 = 0x0001, lane0 = 0x0002) -> accepts every 3 cycles; out_valid pulses 3 cycles apart. After the 3rd pulse out_data={0x0003,0x0006} and acc_cnt=3.
- Wrap (MODE=0): lane0 accumulates 0xFFFF then 0x0002 -> lane0=0x0001, ovf=2'b01. Lane1 is unaffected with ovf[1]=0.
- Unsigned saturate (MODE=1): 0xFFF0 then 0x0020 -> 0xFFFF, ovf[0]=1. A further +0x0001 keeps 0xFFFF.
- Signed saturate (MODE=2): 0x7FF0 then 0x0020 -> 0x7FFF. After usr_clr, 0x8000 then 0xFFFF -> 0x8000. ovf is set in both cases.
- Clear mid-flight: accept a vector, assert usr_clr one cycle later -> no out_valid, out_data=0, acc_cnt=0, in_ready=1 the cycle after usr_clr drops.
- Reset: rst=0 while busy -> all outputs 0, in_ready=0 during reset. Counter saturation (CNT_W=2): 5 accepts -> acc_cnt=3.

Source files
------------

// File: rtl/selfadd_pkg.sv
// Shared definitions for the self-accumulating lane bank.
// Contents:
//   MODE_WRAP / MODE_USAT / MODE_SSAT : arithmetic mode selectors
//   sat_sel_e                         : which value a lane writes back
//   sat_t                             : overflow flag plus result selector
//   sat_result()                      : per-mode overflow/saturation decision
// The decision works on carry and sign bits only, so one function serves
// every lane width. Each lane builds its own width-specific constants.
package selfadd_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_USAT = 1;
  localparam int MODE_SSAT = 2;

  typedef enum logic [1:0] {
    SEL_RAW  = 2'd0,  // low WIDTH bits of the sum
    SEL_UMAX = 2'd1,  // all ones
    SEL_SMAX = 2'd2,  // 0x7F..F
    SEL_SMIN = 2'd3   // 0x80..0
  } sat_sel_e;

  typedef struct packed {
    logic     ovf;
    sat_sel_e sel;
  } sat_t;

  // carry  : bit WIDTH of the zero-extended sum
  // sign_* : MSBs of operand a, operand b and the truncated result
  function automatic sat_t sat_result(int mode, logic carry, logic sign_a,
                                      logic sign_b, logic sign_r);
    sat_t r;
    r.ovf = 1'b0;
    r.sel = SEL_RAW;
    case (mode)
      MODE_USAT: begin
        r.ovf = carry;
        r.sel = carry ? SEL_UMAX : SEL_RAW;
      end
      MODE_SSAT: begin
        r.ovf = (sign_a == sign_b) && (sign_r != sign_a);
        if (r.ovf) r.sel = sign_a ? SEL_SMIN : SEL_SMAX;
      end
      default: begin
        r.ovf = carry;
        r.sel = SEL_RAW;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/selfadd_accum_lanes_if.sv
// Handshake and result bus of the self-accumulating lane bank.
// Signals:
//   in_valid / in_ready / in_data : input vector transfer (lane i at [i*WIDTH +: WIDTH])
//   out_data                      : registered accumulator contents
//   out_valid                     : one-cycle pulse after an accumulator update
//   ovf                           : sticky per-lane overflow flags
//   acc_cnt                       : saturating count of accumulations since clear
// master = the feeding datapath, slave = the accumulator bank.
interface selfadd_accum_lanes_if #(
  parameter int LANES = 2,
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH-1:0]   in_data;
  logic [LANES*WIDTH-1:0]   out_data;
  logic                     out_valid;
  logic [LANES-1:0]         ovf;
  logic [CNT_W-1:0]         acc_cnt;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_data, out_valid, ovf, acc_cnt
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_data, out_valid, ovf, acc_cnt
  );

endinterface

// File: rtl/selfadd_lane.sv
// One accumulator lane: operand capture, adder with mode logic, ADD_LAT-deep
// result pipeline, accumulator register and sticky overflow bit.
// Ports:
//   clk, rst (sync, active-low), clr (sync user clear, active-high)
//   take   : capture din and the current accumulator as operands
//   commit : write the pipeline output into acc / ovf on this edge
//   din    : lane input
//   acc    : accumulator value
//   ovf    : sticky overflow flag
module selfadd_lane
  import selfadd_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADD_LAT = 2,
  parameter int MODE    = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             take,
  input  logic             commit,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;
  sat_t             sat;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] fin_res;
  logic             fin_ovf;

  // Stage 0. The snapshot of acc is safe because the top never accepts a
  // new vector while an earlier one is still in the pipeline.
  always_ff @(posedge clk) begin
    if (take) begin
      op_a <= din;
      op_b <= acc;
    end
  end

  assign sum = {1'b0, op_a} + {1'b0, op_b};
  assign sat = sat_result(MODE, sum[WIDTH], op_a[WIDTH-1], op_b[WIDTH-1], sum[WIDTH-1]);

  always_comb begin
    res_c = sum[WIDTH-1:0];
    case (sat.sel)
      SEL_UMAX: res_c = '1;
      SEL_SMAX: res_c = SMAX;
      SEL_SMIN: res_c = SMIN;
      default:  res_c = sum[WIDTH-1:0];
    endcase
  end

  // Remaining ADD_LAT-1 stages carry {ovf, result}. They need no reset:
  // nothing leaves them unless commit is raised by the top's busy counter,
  // which reset and clear zero.
  if (ADD_LAT == 1) begin : g_direct
    assign fin_res = res_c;
    assign fin_ovf = sat.ovf;
  end else begin : g_pipe
    logic [WIDTH:0] pipe_q [ADD_LAT-1];

    always_ff @(posedge clk) begin
      pipe_q[0] <= {sat.ovf, res_c};
      for (int k = 1; k < ADD_LAT-1; k++) pipe_q[k] <= pipe_q[k-1];
    end

    assign {fin_ovf, fin_res} = pipe_q[ADD_LAT-2];
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (commit) begin
      acc <= fin_res;
      ovf <= ovf | fin_ovf;
    end
  end

endmodule

// File: rtl/selfadd_accum_lanes.sv
// Multi-lane self-accumulating register bank. Every accepted input vector is
// added lane-by-lane into the accumulators through an ADD_LAT-deep adder.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous reset, active-low
//   usr_clr : synchronous user clear, active-high
//   bus     : slave side of selfadd_accum_lanes_if (handshake + results)
// The handshake, busy down-counter, out_valid pulse and acc_cnt live here;
// arithmetic and overflow tracking live in selfadd_lane.
module selfadd_accum_lanes
  import selfadd_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int WIDTH   = 16,
  parameter int ADD_LAT = 2,
  parameter int MODE    = MODE_WRAP,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  usr_clr,
  selfadd_accum_lanes_if.slave  bus
);

  localparam int BW = $clog2(ADD_LAT + 1);

  logic [BW-1:0]          busy_cnt;
  logic                   take;
  logic                   commit;
  logic                   out_valid;
  logic [CNT_W-1:0]       acc_cnt;
  logic [LANES-1:0]       ovf_l;
  logic [LANES*WIDTH-1:0] acc_flat;

  // A single vector in flight at a time removes the read-after-write
  // hazard on the accumulator without a bypass path.
  assign bus.in_ready = rst && !usr_clr && (busy_cnt == '0);
  assign take         = bus.in_valid && bus.in_ready;
  // Terminal count: the edge that takes busy_cnt from 1 to 0 is E0+ADD_LAT.
  assign commit       = (busy_cnt == BW'(1));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    selfadd_lane #(
      .WIDTH   (WIDTH),
      .ADD_LAT (ADD_LAT),
      .MODE    (MODE)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (usr_clr),
      .take   (take),
      .commit (commit),
      .din    (bus.in_data[i*WIDTH +: WIDTH]),
      .acc    (acc_flat[i*WIDTH +: WIDTH]),
      .ovf    (ovf_l[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst || usr_clr) begin
      busy_cnt  <= '0;
      out_valid <= 1'b0;
      acc_cnt   <= '0;
    end else begin
      out_valid <= commit;
      if (take) begin
        busy_cnt <= BW'(ADD_LAT);
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - BW'(1);
      end
      if (commit && (acc_cnt != '1)) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_data  = acc_flat;
  assign bus.out_valid = out_valid;
  assign bus.ovf       = ovf_l;
  assign bus.acc_cnt   = acc_cnt;

endmodule

// File: tb/tb_selfadd_accum_lanes.sv
// Bench for selfadd_accum_lanes. Four instances (LANES=2, WIDTH=16, ADD_LAT=2):
//   dut0 MODE 0, dut1 MODE 1, dut2 MODE 2, dut3 MODE 0 with CNT_W=2.
// A reference model predicts each accumulation when the transfer is driven
// and queues it with its due edge; outputs are compared when they appear.
module tb_selfadd_accum_lanes;

  localparam int ND = 4;
  localparam int LAT = 2;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  ovf;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [ND-1:0] d_vld;
  logic [ND-1:0] d_clr;
  logic [31:0] d_data [ND];

  logic [ND-1:0] o_rdy;
  logic [ND-1:0] o_vld;
  logic [31:0] o_data [ND];
  logic [1:0]  o_ovf  [ND];
  logic [7:0]  o_cnt  [ND];

  exp_t        sb [ND][$];
  logic [15:0] m_acc [ND][2];
  logic [1:0]  m_ovf [ND];
  int          m_cnt [ND];
  logic [31:0] sh_data [ND];
  logic [1:0]  sh_ovf  [ND];
  logic [7:0]  sh_cnt  [ND];
  logic [ND-1:0] acc_now;
  int          edge_n;
  int          tests;
  int          fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int MD = (g == 1) ? 1 : (g == 2) ? 2 : 0;
    localparam int CW = (g == 3) ? 2 : 8;

    selfadd_accum_lanes_if #(.LANES(2), .WIDTH(16), .CNT_W(CW)) bus ();

    assign bus.in_valid = d_vld[g];
    assign bus.in_data  = d_data[g];
    assign o_rdy[g]     = bus.in_ready;
    assign o_vld[g]     = bus.out_valid;
    assign o_data[g]    = bus.out_data;
    assign o_ovf[g]     = bus.ovf;
    assign o_cnt[g]     = 8'(bus.acc_cnt);

    selfadd_accum_lanes #(
      .LANES(2), .WIDTH(16), .ADD_LAT(LAT), .MODE(MD), .CNT_W(CW)
    ) dut (
      .clk     (clk),
      .rst     (rst_n),
      .usr_clr (d_clr[g]),
      .bus     (bus)
    );
  end

  function automatic int mode_of(int d);
    return (d == 1) ? 1 : (d == 2) ? 2 : 0;
  endfunction

  function automatic int cnt_max(int d);
    return (d == 3) ? 3 : 255;
  endfunction

  task automatic ref_add(input int mode, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic o);
    int su;
    int ss;
    su = int'(a) + int'(b);
    ss = int'($signed(a)) + int'($signed(b));
    case (mode)
      1: begin
        o = (su > 65535);
        r = o ? 16'hFFFF : su[15:0];
      end
      2: begin
        if (ss > 32767) begin
          r = 16'h7FFF; o = 1'b1;
        end else if (ss < -32768) begin
          r = 16'h8000; o = 1'b1;
        end else begin
          r = ss[15:0]; o = 1'b0;
        end
      end
      default: begin
        o = (su > 65535);
        r = su[15:0];
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic zero_model(input int d);
    sb[d].delete();
    m_acc[d][0] = '0;
    m_acc[d][1] = '0;
    m_ovf[d]    = '0;
    m_cnt[d]    = 0;
    sh_data[d]  = '0;
    sh_ovf[d]   = '0;
    sh_cnt[d]   = '0;
  endtask

  // One clock cycle: check in_ready and predict transfers before the edge,
  // check out_valid and the visible results after it.
  task automatic tick();
    logic        exp_rdy;
    logic        exp_vld;
    exp_t        e;
    logic [15:0] r;
    logic        o;
    #1;
    for (int d = 0; d < ND; d++) begin
      exp_rdy = rst_n && !d_clr[d] && (sb[d].size() == 0);
      chk($sformatf("dut%0d in_ready", d), 64'(o_rdy[d]), 64'(exp_rdy));
      acc_now[d] = d_vld[d] && exp_rdy;
      if (acc_now[d]) begin
        e.data = '0;
        for (int l = 0; l < 2; l++) begin
          ref_add(mode_of(d), m_acc[d][l], d_data[d][l*16 +: 16], r, o);
          m_acc[d][l]         = r;
          m_ovf[d][l]         = m_ovf[d][l] | o;
          e.data[l*16 +: 16]  = r;
        end
        if (m_cnt[d] < cnt_max(d)) m_cnt[d]++;
        e.ovf = m_ovf[d];
        e.cnt = 8'(m_cnt[d]);
        e.due = edge_n + 1 + LAT;
        sb[d].push_back(e);
      end
    end
    @(posedge clk);
    edge_n++;
    for (int d = 0; d < ND; d++) begin
      if (!rst_n || d_clr[d]) zero_model(d);
    end
    #1;
    for (int d = 0; d < ND; d++) begin
      exp_vld = (sb[d].size() != 0) && (sb[d][0].due == edge_n);
      chk($sformatf("dut%0d out_valid", d), 64'(o_vld[d]), 64'(exp_vld));
      if (exp_vld) begin
        e = sb[d].pop_front();
        sh_data[d] = e.data;
        sh_ovf[d]  = e.ovf;
        sh_cnt[d]  = e.cnt;
      end
      chk($sformatf("dut%0d out_data", d), 64'(o_data[d]), 64'(sh_data[d]));
      chk($sformatf("dut%0d ovf", d),      64'(o_ovf[d]),  64'(sh_ovf[d]));
      chk($sformatf("dut%0d acc_cnt", d),  64'(o_cnt[d]),  64'(sh_cnt[d]));
    end
  endtask

  // Holds in_valid high with data until the transfer happens (bounded).
  task automatic send(input int d, input logic [31:0] data, output int edge_at);
    d_vld[d]  = 1'b1;
    d_data[d] = data;
    edge_at   = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_now[d]) begin
        edge_at = edge_n;
        break;
      end
    end
    chk($sformatf("dut%0d accept within bound", d), 64'(edge_at >= 0), 64'(1));
  endtask

  task automatic drain(input int d);
    d_vld[d] = 1'b0;
    for (int i = 0; i < 20 && sb[d].size() != 0; i++) tick();
    chk($sformatf("dut%0d drained within bound", d), 64'(sb[d].size()), 64'(0));
    tick();
  endtask

  task automatic pulse_clr(input int d);
    d_vld[d] = 1'b0;
    d_clr[d] = 1'b1;
    tick();
    d_clr[d] = 1'b0;
    tick();
  endtask

  initial begin
    int e1, e2, e3, ex;
    tests  = 0;
    fails  = 0;
    edge_n = 0;
    rst_n  = 1'b0;
    d_vld  = '0;
    d_clr  = '0;
    acc_now = '0;
    for (int d = 0; d < ND; d++) begin
      d_data[d] = '0;
      zero_model(d);
    end

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Held valid: one transfer every ADD_LAT+1 cycles.
    send(0, 32'h0001_0002, e1);
    send(0, 32'h0001_0002, e2);
    send(0, 32'h0001_0002, e3);
    chk("dut0 accept gap 1-2", 64'(e2 - e1), 64'(3));
    chk("dut0 accept gap 2-3", 64'(e3 - e2), 64'(3));
    drain(0);
    chk("dut0 sum after 3", 64'(o_data[0]), 64'(32'h0003_0006));
    chk("dut0 cnt after 3", 64'(o_cnt[0]),  64'(3));

    // Wrap in lane 0, lane 1 untouched.
    pulse_clr(0);
    send(0, 32'h0000_FFFF, ex);
    send(0, 32'h0000_0002, ex);
    drain(0);
    chk("dut0 wrap data", 64'(o_data[0]), 64'(32'h0000_0001));
    chk("dut0 wrap ovf",  64'(o_ovf[0]),  64'(2'b01));

    // Clear one cycle after a transfer: result discarded.
    send(0, 32'h0005_0005, ex);
    d_vld[0] = 1'b0;
    d_clr[0] = 1'b1;
    tick();
    d_clr[0] = 1'b0;
    repeat (4) tick();
    chk("dut0 midclr data", 64'(o_data[0]), 64'(0));
    chk("dut0 midclr cnt",  64'(o_cnt[0]),  64'(0));

    // Unsigned saturate.
    send(1, 32'h0000_FFF0, ex);
    send(1, 32'h0000_0020, ex);
    drain(1);
    chk("dut1 usat data", 64'(o_data[1]), 64'(32'h0000_FFFF));
    chk("dut1 usat ovf",  64'(o_ovf[1]),  64'(2'b01));
    send(1, 32'h0000_0001, ex);
    drain(1);
    chk("dut1 usat hold", 64'(o_data[1]), 64'(32'h0000_FFFF));

    // Signed saturate, positive then negative.
    send(2, 32'h0000_7FF0, ex);
    send(2, 32'h0000_0020, ex);
    drain(2);
    chk("dut2 ssat pos data", 64'(o_data[2]), 64'(32'h0000_7FFF));
    chk("dut2 ssat pos ovf",  64'(o_ovf[2]),  64'(2'b01));
    pulse_clr(2);
    chk("dut2 cleared ovf", 64'(o_ovf[2]), 64'(0));
    send(2, 32'h0000_8000, ex);
    send(2, 32'h0000_FFFF, ex);
    drain(2);
    chk("dut2 ssat neg data", 64'(o_data[2]), 64'(32'h0000_8000));
    chk("dut2 ssat neg ovf",  64'(o_ovf[2]),  64'(2'b01));

    // Counter saturation with CNT_W=2.
    for (int i = 0; i < 5; i++) send(3, 32'h0001_0001, ex);
    drain(3);
    chk("dut3 cnt sat", 64'(o_cnt[3]), 64'(3));
    chk("dut3 data",    64'(o_data[3]), 64'(32'h0005_0005));

    // Reset while busy.
    send(1, 32'h0001_0001, ex);
    d_vld[1] = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    chk("reset dut1 data", 64'(o_data[1]), 64'(0));
    chk("reset dut1 ovf",  64'(o_ovf[1]),  64'(0));
    chk("reset dut1 cnt",  64'(o_cnt[1]),  64'(0));
    chk("reset dut1 ready", 64'(o_rdy[1]), 64'(0));
    rst_n = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
